pause_ctrl: RTL and testbench

PAUSE_CTRL -- requirements
Module: pause_ctrl

---
 rtl/pause_ctrl.sv | 116 +++++++++++
 tb/tb_pause_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pause_ctrl.sv
// Run/halt/step controller that gates the system clock through o_pause.
// After reset the block holds o_pause for INIT_CYCLES cycles, then boots into
// RUNNING or HALTED. From HALTED a step request releases exactly N cycles.
// Every output is registered from next-state logic, so a request seen at a
// clock edge is reflected on the outputs right after that same edge.
module pause_ctrl #(
  parameter int unsigned INIT_CYCLES = 4,
  parameter bit          BOOT_RUN    = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_run,
  input  logic        i_halt,
  input  logic        i_step,
  input  logic [15:0] i_count,
  input  logic        i_bkpt,
  output logic        o_pause,
  output logic        o_halted,
  output logic        o_bkpt_hit,
  output logic [31:0] o_cycles
);

  typedef enum logic [1:0] {
    S_INIT     = 2'd0,
    S_HALTED   = 2'd1,
    S_RUNNING  = 2'd2,
    S_STEPPING = 2'd3
  } state_t;

  localparam logic [7:0] INIT_LAST = 8'(INIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  init_cnt_q, init_cnt_d;
  logic [15:0] step_cnt_q, step_cnt_d;
  logic        bkpt_d;

  // Next-state logic; request priority is halt > bkpt > step > run.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    step_cnt_d = step_cnt_q;
    bkpt_d     = o_bkpt_hit;
    case (state_q)
      S_INIT: begin
        if (init_cnt_q == INIT_LAST) begin
          state_d    = BOOT_RUN ? S_RUNNING : S_HALTED;
          init_cnt_d = 8'd0;
        end else begin
          init_cnt_d = init_cnt_q + 8'd1;
        end
      end
      S_HALTED: begin
        // A concurrent halt or breakpoint outranks step/run and keeps us halted.
        if (!(i_halt || i_bkpt)) begin
          if (i_step) begin
            state_d    = S_STEPPING;
            step_cnt_d = (i_count == 16'd0) ? 16'd1 : i_count;
            bkpt_d     = 1'b0;
          end else if (i_run) begin
            state_d = S_RUNNING;
            bkpt_d  = 1'b0;
          end
        end
      end
      S_RUNNING: begin
        if (i_halt) begin
          state_d = S_HALTED;
          bkpt_d  = 1'b0;
        end else if (i_bkpt) begin
          state_d = S_HALTED;
          bkpt_d  = 1'b1;
        end
      end
      S_STEPPING: begin
        if (i_halt) begin
          state_d    = S_HALTED;
          bkpt_d     = 1'b0;
          step_cnt_d = 16'd0;
        end else if (i_bkpt) begin
          state_d    = S_HALTED;
          bkpt_d     = 1'b1;
          step_cnt_d = 16'd0;
        end else if (step_cnt_q <= 16'd1) begin
          // Last granted cycle has just elapsed.
          state_d    = S_HALTED;
          step_cnt_d = 16'd0;
        end else begin
          step_cnt_d = step_cnt_q - 16'd1;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // State, counters and registered outputs; o_cycles counts on the current o_pause.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_INIT;
      init_cnt_q <= 8'd0;
      step_cnt_q <= 16'd0;
      o_pause    <= 1'b1;
      o_halted   <= 1'b0;
      o_bkpt_hit <= 1'b0;
      o_cycles   <= 32'd0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      step_cnt_q <= step_cnt_d;
      o_pause    <= (state_d == S_INIT) || (state_d == S_HALTED);
      o_halted   <= (state_d == S_HALTED);
      o_bkpt_hit <= bkpt_d;
      if (!o_pause) o_cycles <= o_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_pause_ctrl.sv
// Bench for pause_ctrl: two instances (boot-to-run and boot-to-halt) share
// stimulus; a cycle-budget model predicts every output each cycle.
module tb_pause_ctrl;

  localparam int INIT_CYCLES = 4;

  logic        clk;
  logic        rst, run, halt, step, bkpt;
  logic [15:0] count;
  logic [1:0]  pause_o, halted_o, bkhit_o;
  logic [31:0] cyc_o [2];

  pause_ctrl #(.INIT_CYCLES(INIT_CYCLES), .BOOT_RUN(1'b0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_run(run), .i_halt(halt), .i_step(step),
    .i_count(count), .i_bkpt(bkpt), .o_pause(pause_o[0]), .o_halted(halted_o[0]),
    .o_bkpt_hit(bkhit_o[0]), .o_cycles(cyc_o[0]));

  pause_ctrl #(.INIT_CYCLES(INIT_CYCLES), .BOOT_RUN(1'b1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_run(run), .i_halt(halt), .i_step(step),
    .i_count(count), .i_bkpt(bkpt), .o_pause(pause_o[1]), .o_halted(halted_o[1]),
    .o_bkpt_hit(bkhit_o[1]), .o_cycles(cyc_o[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: init_left = paused boot cycles still owed; budget = unpaused
  // cycles granted (-1 free running, 0 halted, N remaining step cycles).
  int          m_init [2] = '{0, 0};
  int          m_budget [2] = '{0, 0};
  logic        m_bk [2] = '{1'b0, 1'b0};
  logic [31:0] m_cyc [2] = '{32'd0, 32'd0};

  function automatic bit m_pause(input int i);
    return (m_init[i] > 0) || (m_budget[i] == 0);
  endfunction

  function automatic bit m_halted(input int i);
    return (m_init[i] == 0) && (m_budget[i] == 0);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_init[i] = INIT_CYCLES; m_budget[i] = 0; m_bk[i] = 1'b0; m_cyc[i] = 32'd0;
      end else begin
        if (!m_pause(i)) m_cyc[i] = m_cyc[i] + 32'd1;
        if (m_init[i] > 0) begin
          m_init[i]--;
          if (m_init[i] == 0) m_budget[i] = (i == 1) ? -1 : 0;
        end else if (m_budget[i] == 0) begin
          if (halt || bkpt) ;
          else if (step) begin m_budget[i] = (count == 0) ? 1 : int'(count); m_bk[i] = 1'b0; end
          else if (run) begin m_budget[i] = -1; m_bk[i] = 1'b0; end
        end else begin
          if (halt) begin m_budget[i] = 0; m_bk[i] = 1'b0; end
          else if (bkpt) begin m_budget[i] = 0; m_bk[i] = 1'b1; end
          else if (m_budget[i] > 0) m_budget[i]--;
        end
      end
    end
  end

  // Every-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("m_pause%0d", i), 32'(pause_o[i]), 32'(m_pause(i)));
        chk($sformatf("m_halted%0d", i), 32'(halted_o[i]), 32'(m_halted(i)));
        chk($sformatf("m_bkhit%0d", i), 32'(bkhit_o[i]), 32'(m_bk[i]));
        chk($sformatf("m_cycles%0d", i), cyc_o[i], m_cyc[i]);
      end
    end
  end

  task automatic idle(input int n);
    run = 0; halt = 0; step = 0; bkpt = 0; count = 16'd0; rst = 0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic r, input logic h, input logic s, input logic [15:0] c,
                       input logic b, input logic rs);
    run = r; halt = h; step = s; count = c; bkpt = b; rst = rs;
    @(negedge clk);
    run = 0; halt = 0; step = 0; count = 16'd0; bkpt = 0; rst = 0;
  endtask

  initial begin
    rst = 1; run = 0; halt = 0; step = 0; bkpt = 0; count = 16'd0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_pause0", 32'(pause_o[0]), 1); chk("rst_pause1", 32'(pause_o[1]), 1);
    chk("rst_halted1", 32'(halted_o[1]), 0); chk("rst_bkhit1", 32'(bkhit_o[1]), 0);
    chk("rst_cycles1", cyc_o[1], 0);

    // Boot: 4 paused cycles, then dut1 runs and dut0 halts.
    idle(3);
    chk("init_pause1", 32'(pause_o[1]), 1); chk("init_halted0", 32'(halted_o[0]), 0);
    idle(1);
    chk("boot_pause1", 32'(pause_o[1]), 0); chk("boot_halted0", 32'(halted_o[0]), 1);
    idle(3);
    chk("boot_cycles1", cyc_o[1], 3);

    // Step 3 from HALTED.
    pulse(0, 0, 1, 16'd3, 0, 0);
    chk("step3_pause0", 32'(pause_o[0]), 0);
    idle(2);
    chk("step3_mid0", 32'(pause_o[0]), 0);
    idle(1);
    chk("step3_halted0", 32'(halted_o[0]), 1); chk("step3_cycles0", cyc_o[0], 3);

    // Run, then a breakpoint halts both.
    pulse(1, 0, 0, 16'd0, 0, 0);
    chk("run_pause0", 32'(pause_o[0]), 0);
    pulse(0, 0, 0, 16'd0, 1, 0);
    chk("bkpt_halted0", 32'(halted_o[0]), 1); chk("bkpt_hit1", 32'(bkhit_o[1]), 1);
    pulse(1, 0, 0, 16'd0, 0, 0);
    chk("rerun_bkhit1", 32'(bkhit_o[1]), 0); chk("rerun_pause1", 32'(pause_o[1]), 0);

    // Halt beats breakpoint and clears the flag.
    pulse(0, 1, 0, 16'd0, 1, 0);
    chk("hb_halted1", 32'(halted_o[1]), 1); chk("hb_bkhit1", 32'(bkhit_o[1]), 0);

    // Halt+step+run in HALTED stays halted; step 0 gives one cycle.
    pulse(1, 1, 1, 16'd5, 0, 0);
    chk("hsr_halted0", 32'(halted_o[0]), 1);
    pulse(1, 0, 1, 16'd0, 0, 0);
    chk("step0_pause1", 32'(pause_o[1]), 0);
    idle(1);
    chk("step0_halted1", 32'(halted_o[1]), 1);

    // Early exits from STEPPING.
    pulse(0, 0, 1, 16'd10, 0, 0);
    idle(2);
    pulse(0, 1, 0, 16'd0, 0, 0);
    chk("stephalt_halted0", 32'(halted_o[0]), 1);
    pulse(0, 0, 1, 16'd10, 0, 0);
    idle(1);
    pulse(0, 0, 0, 16'd0, 1, 0);
    chk("stepbk_bkhit0", 32'(bkhit_o[0]), 1);
    pulse(0, 0, 1, 16'd2, 0, 0);
    chk("stepclr_bkhit0", 32'(bkhit_o[0]), 0);
    idle(2);
    chk("step2_halted0", 32'(halted_o[0]), 1);

    // Maximum step count.
    pulse(0, 0, 1, 16'hFFFF, 0, 0);
    idle(65534);
    chk("stepmax_pause1", 32'(pause_o[1]), 0);
    idle(1);
    chk("stepmax_halted1", 32'(halted_o[1]), 1);

    // Reset in the middle of a step; other requests during reset are ignored.
    pulse(0, 0, 1, 16'd100, 0, 0);
    idle(49);
    pulse(1, 0, 1, 16'd7, 0, 1);
    chk("mrst_pause0", 32'(pause_o[0]), 1); chk("mrst_cycles0", cyc_o[0], 0);
    chk("mrst_halted0", 32'(halted_o[0]), 0);
    idle(3);
    chk("reinit_pause1", 32'(pause_o[1]), 1);
    idle(1);
    chk("reboot_pause1", 32'(pause_o[1]), 0); chk("reboot_halted0", 32'(halted_o[0]), 1);
    idle(2);

    // Wrap of the cycle counter from a preloaded value.
    #2;
    force dut1.o_cycles = 32'hFFFF_FFFE;
    m_cyc[1] = 32'hFFFF_FFFE;
    #1;
    release dut1.o_cycles;
    idle(1);
    chk("wrap_a", cyc_o[1], 32'hFFFF_FFFF);
    idle(1);
    chk("wrap_b", cyc_o[1], 32'h0000_0000);
    idle(1);
    chk("wrap_c", cyc_o[1], 32'h0000_0001);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
